// File: rtl/dmem_sync.sv
// Synchronous single-port data memory with valid/ready requests, per-lane write
// masking, an RD_LAT-deep read pipeline and an optional post-reset clear sweep.
//
// state   | meaning
// S_CLEAR | sweeping zeros into every word, requests ignored, busy=1
// S_READY | accepting one read or write per cycle
module dmem_sync #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 512,
    parameter int LANES          = 2,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    input  logic [LANES-1:0]         req_wmask,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = WIDTH / LANES;
    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;
    localparam state_t S_INIT = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            req_ready_q;
    logic            busy_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [RD_LAT-1:0] rv_q;
    logic [WIDTH-1:0]  rd_q [RD_LAT];

    logic             in_range;
    logic             accept;
    logic             wr_en;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data_d;

    // Reset has priority: nothing is accepted on an edge where reset is low.
    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    assign accept   = reset & cs & req_valid & req_ready_q;
    assign wr_en    = accept & req_we & in_range;
    assign rd_acc   = accept & ~req_we;

    always_comb begin
        rd_data_d = '0;
        if (in_range) rd_data_d = mem_q[req_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_INIT;
            clr_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + AW'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q     <= S_READY;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (req_wmask[l]) mem_q[req_addr][l*LW +: LW] <= req_wdata[l*LW +: LW];
            end
        end
    end

    // Data is zeroed when no read enters so rsp_rdata stays 0 while rsp_valid is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_q[i] <= '0;
        end else begin
            rv_q[0] <= rd_acc;
            rd_q[0] <= rd_acc ? rd_data_d : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i] <= rv_q[i-1];
                rd_q[i] <= rd_q[i-1];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rv_q[RD_LAT-1];
    assign rsp_rdata = rd_q[RD_LAT-1];

endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench for dmem_sync: three instances (clear/RD_LAT=3, DEPTH=500/RD_LAT=2,
// no-clear/RD_LAT=1) share one request channel; each test checks its own instance.
module tb_dmem_sync;
    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        cs, req_valid, req_we;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_wmask;
    logic        rdy_a, rdy_b, rdy_c, busy_a, busy_b, busy_c, rv_a, rv_b, rv_c;
    logic [15:0] rd_a, rd_b, rd_c;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_sync #(.WIDTH(16), .DEPTH(512), .LANES(2), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(rst_a), .cs(cs), .req_valid(req_valid), .req_ready(rdy_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .busy(busy_a));

    dmem_sync #(.WIDTH(16), .DEPTH(500), .LANES(2), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(rst_b), .cs(cs), .req_valid(req_valid), .req_ready(rdy_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .busy(busy_b));

    dmem_sync #(.WIDTH(16), .DEPTH(16), .LANES(2), .RD_LAT(1), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .reset(rst_c), .cs(cs), .req_valid(req_valid), .req_ready(rdy_c),
        .req_we(req_we), .req_addr(req_addr[3:0]), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rv_c), .rsp_rdata(rd_c), .busy(busy_c));

    task automatic req(input logic we, input logic [8:0] a, input logic [15:0] d,
                       input logic [1:0] m, input logic c);
        cs = c; req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cs = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wmask = 2'b00;
    endtask

    task automatic settle();
        idle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int which, output logic [15:0] data, output logic got);
        logic v;
        got = 1'b0; data = '0;
        for (int i = 0; i < 8; i++) begin
            v = (which == 0) ? rv_a : (which == 1) ? rv_b : rv_c;
            if (v) begin
                data = (which == 0) ? rd_a : (which == 1) ? rd_b : rd_c;
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int cnt_a, cnt_b, c_rise, overlap;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        idle(); req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({rdy_a, busy_a, rv_a, rd_a} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
            n_fail++; $display("FAIL reset_a: rdy/busy/rv/rd=%b/%b/%b/%h want 0/1/0/0000", rdy_a, busy_a, rv_a, rd_a);
        end
        n_tests++;
        if ({rdy_c, busy_c, rv_c, busy_b} !== 4'b0001) begin
            n_fail++; $display("FAIL reset_bc: rdy_c/busy_c/rv_c/busy_b=%b/%b/%b/%b want 0/0/0/1", rdy_c, busy_c, rv_c, busy_b);
        end
        // Release and hold a write to 0x1FF pending through the clear; it must be ignored.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        cs = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h1FF; req_wdata = 16'hBEEF; req_wmask = 2'b11;
        cnt_a = 0; cnt_b = 0; c_rise = -1; overlap = 0;
        for (int i = 0; i < 700; i++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            if (busy_a && rdy_a) overlap++;
            if (rdy_c && c_rise < 0) c_rise = i;
            if (!busy_a && rdy_a) break;
            @(posedge clk); #1;
        end
        idle();
        n_tests++;
        if (cnt_a !== 512) begin n_fail++; $display("FAIL clear_len_a: busy cycles=%0d want 512", cnt_a); end
        n_tests++;
        if (cnt_b !== 500) begin n_fail++; $display("FAIL clear_len_b: busy cycles=%0d want 500", cnt_b); end
        n_tests++;
        if (c_rise !== 1) begin n_fail++; $display("FAIL noclear_ready: ready after %0d edges want 1", c_rise); end
        n_tests++;
        if (overlap !== 0 || rdy_a !== 1'b1) begin
            n_fail++; $display("FAIL ready_during_clear: overlap=%0d rdy_a=%b want 0/1", overlap, rdy_a);
        end
    endtask

    task automatic test_clear_content();
        logic [15:0] d; logic got;
        req(1'b0, 9'h1FF, 16'h0, 2'b00, 1'b1);
        idle();
        wait_rsp(0, d, got);
        n_tests++;
        if (!got || d !== 16'h0000) begin n_fail++; $display("FAIL clear_read_1ff: got=%b data=%h want 1/0000", got, d); end
        settle();
    endtask

    task automatic test_lane_mask();
        logic [15:0] d; logic got;
        req(1'b1, 9'd5, 16'hABCD, 2'b11, 1'b1);
        req(1'b1, 9'd5, 16'h1234, 2'b01, 1'b1);
        req(1'b1, 9'd5, 16'hFFFF, 2'b00, 1'b1);
        req(1'b0, 9'd5, 16'h0, 2'b00, 1'b1);
        idle();
        wait_rsp(0, d, got);
        n_tests++;
        if (!got || d !== 16'hAB34) begin n_fail++; $display("FAIL lane_mask: got=%b data=%h want 1/ab34", got, d); end
        settle();
    endtask

    task automatic test_short_latency();
        req(1'b0, 9'd5, 16'h0, 2'b00, 1'b1);
        n_tests++;
        if (rv_c !== 1'b1 || rd_c !== 16'hAB34 || rv_b !== 1'b0) begin
            n_fail++; $display("FAIL lat1_c: rv_c=%b rd_c=%h rv_b=%b want 1/ab34/0", rv_c, rd_c, rv_b);
        end
        idle();
        @(posedge clk); #1;
        n_tests++;
        if (rv_c !== 1'b0 || rd_c !== 16'h0 || rv_b !== 1'b1 || rd_b !== 16'hAB34) begin
            n_fail++; $display("FAIL lat2_b: rv_c=%b rd_c=%h rv_b=%b rd_b=%h want 0/0000/1/ab34", rv_c, rd_c, rv_b, rd_b);
        end
        settle();
    endtask

    task automatic test_streaming();
        req(1'b1, 9'd1, 16'h0011, 2'b11, 1'b1);
        req(1'b1, 9'd2, 16'h0022, 2'b11, 1'b1);
        req(1'b1, 9'd3, 16'h0033, 2'b11, 1'b1);
        req(1'b0, 9'd1, 16'h0, 2'b00, 1'b1);
        n_tests++;
        if (rv_a !== 1'b0) begin n_fail++; $display("FAIL stream_early0: rv_a=%b want 0", rv_a); end
        req(1'b0, 9'd2, 16'h0, 2'b00, 1'b1);
        n_tests++;
        if (rv_a !== 1'b0) begin n_fail++; $display("FAIL stream_early1: rv_a=%b want 0", rv_a); end
        req(1'b0, 9'd3, 16'h0, 2'b00, 1'b1);
        idle();
        n_tests++;
        if (rv_a !== 1'b1 || rd_a !== 16'h0011) begin n_fail++; $display("FAIL stream_0: rv=%b rd=%h want 1/0011", rv_a, rd_a); end
        @(posedge clk); #1;
        n_tests++;
        if (rv_a !== 1'b1 || rd_a !== 16'h0022) begin n_fail++; $display("FAIL stream_1: rv=%b rd=%h want 1/0022", rv_a, rd_a); end
        @(posedge clk); #1;
        n_tests++;
        if (rv_a !== 1'b1 || rd_a !== 16'h0033) begin n_fail++; $display("FAIL stream_2: rv=%b rd=%h want 1/0033", rv_a, rd_a); end
        @(posedge clk); #1;
        n_tests++;
        if (rv_a !== 1'b0 || rd_a !== 16'h0) begin n_fail++; $display("FAIL stream_end: rv=%b rd=%h want 0/0000", rv_a, rd_a); end
        settle();
    endtask

    task automatic test_raw_cs();
        logic [15:0] d; logic got;
        req(1'b1, 9'd7, 16'h5A5A, 2'b11, 1'b1);
        req(1'b0, 9'd7, 16'h0, 2'b00, 1'b1);
        idle();
        wait_rsp(0, d, got);
        n_tests++;
        if (!got || d !== 16'h5A5A) begin n_fail++; $display("FAIL raw: got=%b data=%h want 1/5a5a", got, d); end
        settle();
        req(1'b1, 9'd7, 16'hFFFF, 2'b11, 1'b0);
        req(1'b0, 9'd7, 16'h0, 2'b00, 1'b1);
        idle();
        wait_rsp(0, d, got);
        n_tests++;
        if (!got || d !== 16'h5A5A) begin n_fail++; $display("FAIL cs_gate: got=%b data=%h want 1/5a5a", got, d); end
        settle();
    endtask

    task automatic test_out_of_range();
        logic [15:0] d; logic got;
        req(1'b1, 9'd510, 16'h7777, 2'b11, 1'b1);
        req(1'b0, 9'd510, 16'h0, 2'b00, 1'b1);
        idle();
        wait_rsp(1, d, got);
        n_tests++;
        if (!got || d !== 16'h0000) begin n_fail++; $display("FAIL oor_b: got=%b data=%h want 1/0000", got, d); end
        settle();
        req(1'b0, 9'd510, 16'h0, 2'b00, 1'b1);
        idle();
        wait_rsp(0, d, got);
        n_tests++;
        if (!got || d !== 16'h7777) begin n_fail++; $display("FAIL inrange_a: got=%b data=%h want 1/7777", got, d); end
        settle();
    endtask

    task automatic test_reset_midflight();
        logic [15:0] d; logic got;
        int cnt_b, stray;
        req(1'b1, 9'd9, 16'h1111, 2'b11, 1'b1);
        req(1'b0, 9'd9, 16'h0, 2'b00, 1'b1);
        idle();
        rst_b = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (rv_b !== 1'b0 || busy_b !== 1'b1 || rdy_b !== 1'b0) begin
            n_fail++; $display("FAIL midflight_reset: rv_b=%b busy_b=%b rdy_b=%b want 0/1/0", rv_b, busy_b, rdy_b);
        end
        @(posedge clk); #1;
        rst_b = 1'b1;
        cnt_b = 0; stray = 0;
        for (int i = 0; i < 700; i++) begin
            if (busy_b) cnt_b++;
            if (rv_b) stray++;
            if (!busy_b && rdy_b) break;
            @(posedge clk); #1;
        end
        n_tests++;
        if (cnt_b !== 500 || stray !== 0) begin
            n_fail++; $display("FAIL midflight_clear: busy cycles=%0d stray rsp=%0d want 500/0", cnt_b, stray);
        end
        req(1'b0, 9'd9, 16'h0, 2'b00, 1'b1);
        idle();
        wait_rsp(1, d, got);
        n_tests++;
        if (!got || d !== 16'h0000) begin n_fail++; $display("FAIL midflight_cleared: got=%b data=%h want 1/0000", got, d); end
        settle();
    endtask

    initial begin
        test_reset();
        test_clear_content();
        test_lane_mask();
        test_short_latency();
        test_streaming();
        test_raw_cs();
        test_out_of_range();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule

// File: doc/dmem_sync.md
# dmem_sync

Synchronous single-port data memory that replaces the combinational-read, negedge-write store used by the URISC core. Reads and writes go through a valid/ready request channel, with per-lane write masking and a configurable read pipeline latency. An optional hardware clear sequencer zeroes the whole array after reset. The block sits between the core's memory-access stage and the data store. The core must wait for `req_ready` before its first access.

## Interface
Parameters:
- `WIDTH`, 16: data word width in bits; must be divisible by `LANES`.
- `DEPTH`, 512: number of words; need not be a power of two.
- `LANES`, 2: number of write-mask lanes; lane width is `WIDTH/LANES`.
- `RD_LAT`, 1: read latency in cycles; legal range 1..4.
- `CLEAR_ON_RESET`, 1: 1 = zero the array after reset; 0 = array contents are left untouched.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: reset, synchronous, active-low.
- `cs`, input, 1: chip select; a request is accepted only when `cs` is high.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block can accept a request this cycle.
- `req_we`, input, 1: 1 = write, 0 = read.
- `req_addr`, input, `$clog2(DEPTH)`: word address.
- `req_wdata`, input, `WIDTH`: write data.
- `req_wmask`, input, `LANES`: bit i enables write of lane i, i.e. bits `[(i+1)*WIDTH/LANES-1 : i*WIDTH/LANES]`.
- `rsp_valid`, output, 1: read data valid.
- `rsp_rdata`, output, `WIDTH`: read data; 0 whenever `rsp_valid` is low.
- `busy`, output, 1: clear sequence in progress.

## Operation
State machine has two states: CLEAR and READY.

- **Reset** (`reset` low at a rising edge):
  - State goes to CLEAR if `CLEAR_ON_RESET`=1, else to READY.
  - Clear address counter goes to 0.
  - Read pipeline is flushed.
  - Output values while in reset: `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=0, `busy`=`CLEAR_ON_RESET`.
- **CLEAR**:
  - Each cycle, writes 0 to word `clr_cnt`, then increments `clr_cnt`.
  - After writing word `DEPTH-1`, moves to READY.
  - Takes exactly `DEPTH` cycles.
  - `req_ready`=0 and `busy`=1 throughout; requests are ignored, not queued.
- **READY**:
  - `req_ready`=1 and `busy`=0.
  - Accept condition: `cs & req_valid & req_ready` at a rising edge.
- **Accepted write**:
  - Lanes with mask bit 1 take `req_wdata`; other lanes are unchanged.
  - Mask all-zero means no change.
  - No response is generated.
- **Accepted read**:
  - Array is sampled at the accept edge.
  - Data travels through a shift pipeline of `RD_LAT` stages.
- **Throughput**: one request per cycle, any mix of reads and writes.
- **Responses**: no back-pressure; responses are issued in request order.
- **Out-of-range address** (`req_addr` >= `DEPTH`):
  - Write is dropped.
  - Read still produces a response, with `rsp_rdata`=0.
- **Reset mid-operation**:
  - In-flight reads are discarded; no `rsp_valid` is produced for them.
  - Clear restarts from address 0.
  - Array contents are undefined until the clear completes (when `CLEAR_ON_RESET`=1).

## Timing
- **Read latency**:
  - For a read accepted at edge N, `rsp_valid`=1 with the data from edge N+`RD_LAT`-1 until edge N+`RD_LAT`.
  - With `RD_LAT`=1, data appears in the cycle after acceptance.
- **Read-after-write**:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
  - Back-to-back accesses to the same address therefore see write-through ordering.
- **Back-to-back reads**: produce `rsp_valid` high in consecutive cycles.
- **Reset release to first accept**:
  - `CLEAR_ON_RESET`=1: `req_ready` rises `DEPTH` cycles after the first edge with `reset` high.
  - `CLEAR_ON_RESET`=0: `req_ready` rises 1 cycle after that edge.
- **`cs`**: low blocks acceptance but does not stall in-flight reads.
- **Registered outputs**: all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Clear sequence**: `DEPTH`=512, `CLEAR_ON_RESET`=1, hold `reset` low 3 cycles, release.
  - `busy`=1 for exactly 512 cycles, then `req_ready`=1.
  - A read of address 0x1FF returns 0x0000.
- **Lane masking**:
  - Write 0xABCD to address 5 with mask 2'b11, then 0x1234 with mask 2'b01, then 0xFFFF with mask 2'b00.
  - A read of address 5 returns 0xAB34.
- **Latency and streaming**: `RD_LAT`=3, after writing 0x0011/0x0022/0x0033 to addresses 1/2/3, issue reads of 1, 2, 3 on consecutive edges N..N+2.
  - `rsp_valid` is high during cycles after edges N+2..N+4.
  - Data returned is 0x0011, 0x0022, 0x0033, in that order.
- **Read-after-write and `cs` gating**:
  - Write 0x5A5A to address 7 at edge N, read address 7 at edge N+1: returns 0x5A5A.
  - With `cs`=0, a write of 0xFFFF to address 7 is ignored; a later read still returns 0x5A5A.
- **Out-of-range and reset mid-flight**: `DEPTH`=500.
  - Writing address 510 is dropped; reading address 510 returns `rsp_valid`=1 with `rsp_rdata`=0.
  - With `RD_LAT`=2, asserting `reset` low one cycle after a read is accepted: no `rsp_valid` appears for that read, and the clear restarts.
